// File: rtl/lsu_access_ctrl_if.sv
// Word-wide data-memory bus between the load/store sequencer and memory.
// Ports:
//   bus_req   master->slave  request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_wstrb master->slave  byte enables (0000 on reads)
//   bus_wdata master->slave  lane-replicated store data
//   bus_ack   slave->master  access complete
//   bus_rdata slave->master  read word, valid with bus_ack on reads
interface lsu_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_access_ctrl.sv
// Multi-cycle load/store sequencer between the core and a word-wide data bus.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   MemRead/MemWrite  access request for the current instruction
//   LoadStore_Sel     000 B, 001 H, 010 W, 011 BU, 100 HU, others W
//   addr, wdata       byte address and store data
//   stall             combinational core hold
//   load_data,mem_err registered result, valid in DONE, held afterwards
//   bus               master side of the data-memory bus
module lsu_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         LoadStore_Sel,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               stall,
    output logic [31:0]        load_data,
    output logic               mem_err,
    lsu_access_ctrl_if.master  bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_sel;
    logic [1:0]         r_off;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [3:0]         r_bus_wstrb;
    logic [31:0]        r_bus_wdata;
    logic [31:0]        r_load_data;
    logic               r_mem_err;

    logic               w_req;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_misalign;
    logic               w_timeout;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    // Request decode; unknown size codes fall through to word
    assign w_req      = MemRead | MemWrite;
    assign w_is_byte  = (LoadStore_Sel == 3'b000) || (LoadStore_Sel == 3'b011);
    assign w_is_half  = (LoadStore_Sel == 3'b001) || (LoadStore_Sel == 3'b100);
    assign w_misalign = w_is_half ? addr[0] : (!w_is_byte && (addr[1:0] != 2'b00));
    // Last BUSY cycle before abort; an ack in this same cycle still wins
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // stall is gated by rst so the core is released during reset
    assign stall = !rst && (((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY));

    // Store lane steering
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = wdata;
        if (w_is_byte) begin
            w_wstrb = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
        end else if (w_is_half) begin
            w_wstrb = 4'b0011 << addr[1:0];
            w_wdata = {2{wdata[15:0]}};
        end
    end

    // Load lane extract and extension from the latched size/offset
    always_comb begin
        w_byte = bus.bus_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_sel)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b011:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {16'h0, w_half};
            default: w_load = bus.bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = w_misalign ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.bus_ack || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Access context, bus outputs and results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= 3'b000;
            r_off       <= 2'b00;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wstrb <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_load_data <= 32'h0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_sel <= LoadStore_Sel;
                        r_off <= addr[1:0];
                        r_we  <= MemWrite;
                        r_cnt <= '0;
                        if (w_misalign) begin
                            r_mem_err   <= 1'b1;
                            r_load_data <= 32'h0;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= MemWrite;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_wstrb <= MemWrite ? w_wstrb : 4'h0;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.bus_ack) begin
                        r_bus_req   <= 1'b0;
                        r_bus_wstrb <= 4'h0;
                        r_mem_err   <= 1'b0;
                        if (!r_we) begin
                            r_load_data <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_bus_wstrb <= 4'h0;
                        r_mem_err   <= 1'b1;
                        r_load_data <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign load_data     = r_load_data;
    assign mem_err       = r_mem_err;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wstrb = r_bus_wstrb;
    assign bus.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed bench for lsu_access_ctrl (TIMEOUT=4).
module tb_lsu_access_ctrl;
    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  LoadStore_Sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    // Results of the most recent run_access
    int          r_stall_cyc;
    int          r_req_cyc;
    int          r_done;
    logic [31:0] r_load;
    logic        r_err;
    logic        r_stable;
    logic        r_req_in_done;
    logic        c_we;
    logic [31:0] c_addr;
    logic [3:0]  c_wstrb;
    logic [31:0] c_wdata;

    lsu_access_ctrl_if bus_if ();

    lsu_access_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .LoadStore_Sel (LoadStore_Sel),
        .addr          (addr),
        .wdata         (wdata),
        .stall         (stall),
        .load_data     (load_data),
        .mem_err       (mem_err),
        .bus           (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one access (cycle 0 = request cycle) and records what was seen.
    // The request is held until DONE; ack_at is the BUSY cycle index to ack in (-1 never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] sel,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_at);
        int busy_n;
        bit seen;
        busy_n = 0; seen = 0;
        r_stall_cyc = 0; r_req_cyc = 0; r_done = -1; r_stable = 1'b1; r_req_in_done = 1'b0;
        r_load = 32'hx; r_err = 1'bx;
        c_we = 1'b0; c_addr = 32'h0; c_wstrb = 4'h0; c_wdata = 32'h0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; LoadStore_Sel = sel; addr = a; wdata = wd;
        #1;
        if (stall) r_stall_cyc++;
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            #1;
            if (stall) r_stall_cyc++;
            if (bus_if.bus_req) begin
                r_req_cyc++;
                if (!seen) begin
                    c_we = bus_if.bus_we; c_addr = bus_if.bus_addr;
                    c_wstrb = bus_if.bus_wstrb; c_wdata = bus_if.bus_wdata;
                end else if (c_we !== bus_if.bus_we || c_addr !== bus_if.bus_addr ||
                             c_wstrb !== bus_if.bus_wstrb || c_wdata !== bus_if.bus_wdata) begin
                    r_stable = 1'b0;
                end
                seen = 1;
                if (busy_n == ack_at) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rdat;
                end
                busy_n++;
            end
            if (!stall) begin
                r_done = n; r_load = load_data; r_err = mem_err;
                r_req_in_done = bus_if.bus_req;
                MemRead = 1'b0; MemWrite = 1'b0;
                break;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; bus_if.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; LoadStore_Sel = 3'b010;
        addr = 32'h100; wdata = 32'h0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus_if.bus_req); end
        checks++; if (bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wstrb !== 4'h0 || bus_if.bus_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus got we=%b addr=%h wstrb=%b wdata=%h exp all 0",
                               bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata); end
        checks++; if (load_data !== 32'h0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_result got load=%h err=%b exp 0/0", load_data, mem_err); end
        @(negedge clk);
        rst = 1'b0; MemRead = 1'b0;
    endtask

    task automatic test_lw_basic();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++; if (r_done !== 2) begin errors++; $display("FAIL lw_done_cycle got %0d exp 2", r_done); end
        checks++; if (r_stall_cyc !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", r_stall_cyc); end
        checks++; if (r_req_cyc !== 1) begin errors++; $display("FAIL lw_req_cycles got %0d exp 1", r_req_cyc); end
        checks++; if (c_addr !== 32'h100 || c_we !== 1'b0 || c_wstrb !== 4'h0) begin
            errors++; $display("FAIL lw_bus got addr=%h we=%b wstrb=%b exp 100/0/0000", c_addr, c_we, c_wstrb); end
        checks++; if (r_load !== 32'hDEADBEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL lw_result got load=%h err=%b exp deadbeef/0", r_load, r_err); end
        checks++; if (r_req_in_done !== 1'b0) begin errors++; $display("FAIL lw_req_in_done got 1 exp 0"); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  sel_t [6] = '{3'b000, 3'b011, 3'b001, 3'b100, 3'b000, 3'b111};
        logic [31:0] adr_t [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104};
        logic [31:0] exp_t [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                   32'h000080FF, 32'h00000012, 32'h80FF1234};
        for (int i = 0; i < 6; i++) begin
            run_access(1'b1, 1'b0, sel_t[i], adr_t[i], 32'h0, 32'h80FF1234, 1);
            checks++; if (r_load !== exp_t[i] || r_err !== 1'b0) begin
                errors++; $display("FAIL load_ext[%0d] got load=%h err=%b exp %h/0", i, r_load, r_err, exp_t[i]); end
            checks++; if (r_done !== 3 || c_addr !== {adr_t[i][31:2], 2'b00}) begin
                errors++; $display("FAIL load_ext_timing[%0d] got done=%0d addr=%h exp 3/%h",
                                   i, r_done, c_addr, {adr_t[i][31:2], 2'b00}); end
        end
    endtask

    task automatic test_store_lanes();
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
        checks++; if (c_we !== 1'b1 || c_addr !== 32'h200 || c_wstrb !== 4'b0010 || c_wdata !== 32'hABABABAB) begin
            errors++; $display("FAIL sb_lanes got we=%b addr=%h wstrb=%b wdata=%h exp 1/200/0010/abababab",
                               c_we, c_addr, c_wstrb, c_wdata); end
        checks++; if (r_err !== 1'b0 || r_done !== 2) begin
            errors++; $display("FAIL sb_done got err=%b done=%0d exp 0/2", r_err, r_done); end
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0);
        checks++; if (c_we !== 1'b1 || c_addr !== 32'h200 || c_wstrb !== 4'b1100 || c_wdata !== 32'h12341234) begin
            errors++; $display("FAIL sh_lanes got we=%b addr=%h wstrb=%b wdata=%h exp 1/200/1100/12341234",
                               c_we, c_addr, c_wstrb, c_wdata); end
        run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2);
        checks++; if (c_wstrb !== 4'b1111 || c_wdata !== 32'hCAFEF00D || r_stable !== 1'b1) begin
            errors++; $display("FAIL sw_lanes got wstrb=%b wdata=%h stable=%b exp 1111/cafef00d/1",
                               c_wstrb, c_wdata, r_stable); end
        checks++; if (r_done !== 4 || r_req_cyc !== 3 || r_stall_cyc !== 4) begin
            errors++; $display("FAIL sw_wait got done=%0d req=%0d stall=%0d exp 4/3/4", r_done, r_req_cyc, r_stall_cyc); end
    endtask

    task automatic test_misalign();
        logic        rd_t  [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  sel_t [3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] adr_t [3] = '{32'h102, 32'h101, 32'h103};
        for (int i = 0; i < 3; i++) begin
            run_access(rd_t[i], !rd_t[i], sel_t[i], adr_t[i], 32'h5555, 32'h0, 0);
            checks++; if (r_done !== 1 || r_stall_cyc !== 1 || r_req_cyc !== 0) begin
                errors++; $display("FAIL misalign_timing[%0d] got done=%0d stall=%0d req=%0d exp 1/1/0",
                                   i, r_done, r_stall_cyc, r_req_cyc); end
            checks++; if (r_err !== 1'b1) begin
                errors++; $display("FAIL misalign_err[%0d] got %b exp 1", i, r_err); end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, -1);
        checks++; if (r_req_cyc !== 4 || r_done !== 5 || r_stall_cyc !== 5) begin
            errors++; $display("FAIL timeout_timing got req=%0d done=%0d stall=%0d exp 4/5/5", r_req_cyc, r_done, r_stall_cyc); end
        checks++; if (r_err !== 1'b1 || r_load !== 32'h0) begin
            errors++; $display("FAIL timeout_result got err=%b load=%h exp 1/0", r_err, r_load); end
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 3);
        checks++; if (r_err !== 1'b0 || r_load !== 32'h11223344 || r_done !== 5) begin
            errors++; $display("FAIL ack_at_timeout got err=%b load=%h done=%0d exp 0/11223344/5", r_err, r_load, r_done); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        MemRead = 1'b1; LoadStore_Sel = 3'b010; addr = 32'h600;
        @(negedge clk);
        #1;
        checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL midrst_pre_req got %b exp 1", bus_if.bus_req); end
        rst = 1'b1;
        #1;
        checks++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL midrst_drop got req=%b stall=%b exp 0/0", bus_if.bus_req, stall); end
        @(negedge clk);
        rst = 1'b0; MemRead = 1'b0;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0);
        checks++; if (r_done !== 2 || r_load !== 32'h0BADF00D || r_err !== 1'b0) begin
            errors++; $display("FAIL midrst_recover got done=%0d load=%h err=%b exp 2/0badf00d/0", r_done, r_load, r_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1;
        run_access(1'b0, 1'b1, 3'b010, 32'h500, 32'h1, 32'h0, 0);
        a1 = c_addr;
        checks++; if (r_req_cyc !== 1 || r_req_in_done !== 1'b0 || r_done !== 2) begin
            errors++; $display("FAIL b2b_first got req=%0d in_done=%b done=%0d exp 1/0/2", r_req_cyc, r_req_in_done, r_done); end
        run_access(1'b0, 1'b1, 3'b010, 32'h504, 32'h2, 32'h0, 0);
        checks++; if (r_req_cyc !== 1 || r_req_in_done !== 1'b0 || r_done !== 2) begin
            errors++; $display("FAIL b2b_second got req=%0d in_done=%b done=%0d exp 1/0/2", r_req_cyc, r_req_in_done, r_done); end
        checks++; if (a1 !== 32'h500 || c_addr !== 32'h504 || c_wdata !== 32'h2) begin
            errors++; $display("FAIL b2b_addrs got %h,%h wdata=%h exp 500,504 wdata=2", a1, c_addr, c_wdata); end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_load_extend();
        test_store_lanes();
        test_misalign();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
